// File: rtl/data_mem_lsu_if.sv
// Request/response bundle between the datapath (master) and the load/store unit (slave).
`timescale 1ns/1ps
interface data_mem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        fault;
  logic [31:0] fault_addr;

  modport master (
    output req_valid, req_write, funct3, addr, wdata,
    input  req_ready, rdata, rdata_valid, fault, fault_addr
  );

  modport slave (
    input  req_valid, req_write, funct3, addr, wdata,
    output req_ready, rdata, rdata_valid, fault, fault_addr
  );
endinterface

// File: rtl/data_mem_lsu.sv
// RV32I load/store unit with integrated synchronous data memory.
// Optional LSU_MISALIGN_TRAP_EN: fault misaligned half/word accesses instead of truncating them.
//
// state | meaning
// IDLE  | ready for a request; stores and faults complete here
// LOAD  | registered word presented on rdata, rdata_valid high
`timescale 1ns/1ps
module data_mem_lsu #(
  parameter int DEPTH_WORDS = 64
) (
  input logic           clk,
  input logic           reset,
  data_mem_lsu_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t      state;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] word_q;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic        ready_q;
  logic        valid_q;
  logic        fault_q;
  logic [31:0] fault_addr_q;

  logic [AW-1:0] idx;
  logic [1:0]    off_raw;
  logic [1:0]    off_eff;
  logic          is_half;
  logic          is_word;
  logic          legal_f3;
  logic          misalign;
  logic          req_fault;
  logic          accept;
  logic [3:0]    be;
  logic [31:0]   wd;
  logic [31:0]   shifted;
  logic [31:0]   rdata_c;
  logic          unused_addr_bits;

  // Addresses wrap modulo the memory size; the high bits are deliberately dropped.
  assign unused_addr_bits = &{1'b0, bus.addr[31:AW+2]};
  assign accept = bus.req_valid && ready_q;

  always_comb begin
    idx     = bus.addr[AW+1:2];
    off_raw = bus.addr[1:0];
    is_half = (bus.funct3[1:0] == 2'b01);
    is_word = (bus.funct3[1:0] == 2'b10);
    if (bus.req_write)
      legal_f3 = bus.funct3 inside {3'b000, 3'b001, 3'b010};
    else
      legal_f3 = bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
`ifdef LSU_MISALIGN_TRAP_EN
    misalign = (is_half && off_raw[0]) || (is_word && (off_raw != 2'b00));
    off_eff  = off_raw;
`else
    misalign = 1'b0;
    off_eff  = is_word ? 2'b00 : (is_half ? {off_raw[1], 1'b0} : off_raw);
`endif
    req_fault = !legal_f3 || misalign;
    if (is_word)
      be = 4'b1111;
    else if (is_half)
      be = 4'b0011 << off_eff;
    else
      be = 4'b0001 << off_eff;
    if (is_word)
      wd = bus.wdata;
    else if (is_half)
      wd = {2{bus.wdata[15:0]}};
    else
      wd = {4{bus.wdata[7:0]}};
  end

  // Memory has no reset so contents survive a controller reset.
  always_ff @(posedge clk) begin
    if (accept && bus.req_write && !req_fault) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i])
          mem[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      word_q       <= 32'h0;
      off_q        <= 2'b00;
      f3_q         <= 3'b000;
      ready_q      <= 1'b1;
      valid_q      <= 1'b0;
      fault_q      <= 1'b0;
      fault_addr_q <= 32'h0;
    end else begin
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (req_fault) begin
              fault_q      <= 1'b1;
              fault_addr_q <= bus.addr;
            end else if (!bus.req_write) begin
              word_q  <= mem[idx];
              off_q   <= off_eff;
              f3_q    <= bus.funct3;
              valid_q <= 1'b1;
              ready_q <= 1'b0;
              state   <= LOAD;
            end
          end
        end
        LOAD: begin
          ready_q <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Word loads always carry off_q = 0, so the shifted word is the whole word.
  always_comb begin
    shifted = word_q >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  rdata_c = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  rdata_c = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  rdata_c = {24'h0, shifted[7:0]};
      3'b101:  rdata_c = {16'h0, shifted[15:0]};
      default: rdata_c = shifted;
    endcase
  end

  assign bus.req_ready   = ready_q;
  assign bus.rdata_valid = valid_q;
  assign bus.rdata       = rdata_c;
  assign bus.fault       = fault_q;
  assign bus.fault_addr  = fault_addr_q;
endmodule

// File: tb/tb_data_mem_lsu.sv
// Self-checking bench for data_mem_lsu: byte-array reference model checked every cycle plus literal checks.
`timescale 1ns/1ps
module tb_data_mem_lsu;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  data_mem_lsu_if bus ();

  data_mem_lsu #(.DEPTH_WORDS(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference model: byte-addressed memory and the expected outputs.
  logic [7:0]  mm [4*DEPTH];
  logic        exp_ready = 1'b1;
  logic        exp_valid = 1'b0;
  logic        exp_fault = 1'b0;
  logic [31:0] exp_faddr = 32'h0;
  logic [31:0] exp_rdata = 32'h0;
  logic        m_acc;

  function automatic int nbytes(logic [2:0] f);
    return 1 << f[1:0];
  endfunction

  function automatic int m_base(logic [2:0] f, logic [31:0] a);
    int b = int'(a % (4*DEPTH));
    return b - (b % nbytes(f));
  endfunction

  function automatic bit m_is_fault(logic wr, logic [2:0] f, logic [31:0] a);
    bit legal = wr ? (f inside {3'd0, 3'd1, 3'd2}) : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal) return 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
    if ((a % nbytes(f)) != 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load(logic [2:0] f, logic [31:0] a);
    int n = nbytes(f);
    int base = m_base(f, a);
    logic [31:0] v = 32'h0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = mm[base + k];
    if (!f[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  function automatic void m_store(logic [2:0] f, logic [31:0] a, logic [31:0] d);
    int n = nbytes(f);
    int base = m_base(f, a);
    for (int k = 0; k < n; k++) mm[base + k] = d[8*k +: 8];
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_ready = 1'b1;
      exp_valid = 1'b0;
      exp_fault = 1'b0;
      exp_faddr = 32'h0;
      exp_rdata = 32'h0;
    end else begin
      m_acc = bus.req_valid && exp_ready;
      exp_valid = 1'b0;
      exp_fault = 1'b0;
      exp_ready = 1'b1;
      if (m_acc) begin
        if (m_is_fault(bus.req_write, bus.funct3, bus.addr)) begin
          exp_fault = 1'b1;
          exp_faddr = bus.addr;
        end else if (bus.req_write) begin
          m_store(bus.funct3, bus.addr, bus.wdata);
        end else begin
          exp_rdata = m_load(bus.funct3, bus.addr);
          exp_valid = 1'b1;
          exp_ready = 1'b0;
        end
      end
    end
  end

  // rdata is checked every cycle: it always reflects the last registered load.
  always @(negedge clk) begin
    chk("req_ready",   32'(bus.req_ready),   32'(exp_ready));
    chk("rdata_valid", 32'(bus.rdata_valid), 32'(exp_valid));
    chk("fault",       32'(bus.fault),       32'(exp_fault));
    chk("fault_addr",  bus.fault_addr,       exp_faddr);
    chk("rdata",       bus.rdata,            exp_rdata);
  end

  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.funct3    = f3;
    bus.addr      = a;
    bus.wdata     = d;
    @(negedge clk);
    while (!bus.req_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 32'(bus.req_ready), 32'h1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.funct3    = 3'b000;
    bus.addr      = 32'h0;
    bus.wdata     = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'h1);
    chk("rst_rdata", bus.rdata, 32'h0);
    reset = 1'b0;

    // back-to-back clear of the whole memory
    for (int i = 0; i < DEPTH; i++) do_req(1'b1, 3'b010, 32'(4*i), 32'h0);

    do_req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
    do_req(1'b0, 3'b010, 32'h10, 32'h0);
    @(negedge clk);
    chk("lw_10", bus.rdata, 32'hDEAD_BEEF);
    chk("lw_10_valid", 32'(bus.rdata_valid), 32'h1);
    chk("lw_10_busy", 32'(bus.req_ready), 32'h0);

    do_req(1'b1, 3'b010, 32'h20, 32'h0);
    do_req(1'b1, 3'b000, 32'h21, 32'h1234_5680);
    do_req(1'b0, 3'b000, 32'h21, 32'h0);
    @(negedge clk) chk("lb_21", bus.rdata, 32'hFFFF_FF80);
    do_req(1'b0, 3'b100, 32'h21, 32'h0);
    @(negedge clk) chk("lbu_21", bus.rdata, 32'h0000_0080);
    do_req(1'b0, 3'b010, 32'h20, 32'h0);
    @(negedge clk) chk("lw_20", bus.rdata, 32'h0000_8000);

    do_req(1'b1, 3'b010, 32'h30, 32'h1122_3344);
    do_req(1'b1, 3'b001, 32'h32, 32'hABCD_8001);
    do_req(1'b0, 3'b001, 32'h32, 32'h0);
    @(negedge clk) chk("lh_32", bus.rdata, 32'hFFFF_8001);
    do_req(1'b0, 3'b101, 32'h32, 32'h0);
    @(negedge clk) chk("lhu_32", bus.rdata, 32'h0000_8001);
    do_req(1'b0, 3'b010, 32'h30, 32'h0);
    @(negedge clk) chk("lw_30", bus.rdata, 32'h8001_3344);

    do_req(1'b1, 3'b010, 32'h40, 32'hCAFE_F00D);
    do_req(1'b0, 3'b010, 32'h41, 32'h0);
    @(negedge clk);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lw_41_fault", 32'(bus.fault), 32'h1);
    chk("lw_41_faddr", bus.fault_addr, 32'h41);
    chk("lw_41_novalid", 32'(bus.rdata_valid), 32'h0);
`else
    chk("lw_41", bus.rdata, 32'hCAFE_F00D);
`endif
    do_req(1'b1, 3'b001, 32'h43, 32'h0000_5555);
    do_req(1'b0, 3'b010, 32'h40, 32'h0);
    @(negedge clk);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("sh_43", bus.rdata, 32'hCAFE_F00D);
`else
    chk("sh_43", bus.rdata, 32'h5555_F00D);
`endif

    do_req(1'b0, 3'b011, 32'h14, 32'h0);
    @(negedge clk);
    chk("ld011_fault", 32'(bus.fault), 32'h1);
    chk("ld011_faddr", bus.fault_addr, 32'h14);
    do_req(1'b1, 3'b100, 32'h10, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("st100_fault", 32'(bus.fault), 32'h1);
    chk("st100_faddr", bus.fault_addr, 32'h10);
    do_req(1'b0, 3'b010, 32'h10, 32'h0);
    @(negedge clk) chk("st100_nowrite", bus.rdata, 32'hDEAD_BEEF);

    // reset lands in the LOAD cycle
    do_req(1'b0, 3'b010, 32'h30, 32'h0);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rstload_valid", 32'(bus.rdata_valid), 32'h0);
    chk("rstload_rdata", bus.rdata, 32'h0);
    chk("rstload_ready", 32'(bus.req_ready), 32'h1);
    #2 reset = 1'b0;
    do_req(1'b0, 3'b010, 32'h10, 32'h0);
    @(negedge clk) chk("retain_10", bus.rdata, 32'hDEAD_BEEF);

    do_req(1'b1, 3'b010, 32'(32'h10 + 4*DEPTH), 32'h0BAD_F00D);
    do_req(1'b0, 3'b010, 32'h10, 32'h0);
    @(negedge clk) chk("alias_10", bus.rdata, 32'h0BAD_F00D);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
